// File: rtl/sd_loader_pkg.sv
// Shared definitions for the multi-region SD loader: FSM encoding, sector size
// and a width helper used for index and counter sizing.
package sd_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SELECT,
      ST_ISSUE,
      ST_WAIT_BUSY,
      ST_XFER,
      ST_DONE
   } state_t;

   localparam int SECTOR_WORDS = 256;
   // Per-sector word tally saturates well above SECTOR_WORDS so overruns stay visible.
   localparam int SEC_CNT_W    = 10;

   function automatic int clog2_min1(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/sd_word_packer.sv
// Packs 16-bit words into OUT_W beats, earliest word in the LSBs; a word flagged
// last flushes the beat early with its unfilled upper lanes zeroed.
module sd_word_packer
   import sd_loader_pkg::*;
#(
   parameter int OUT_W = 32,
   parameter int RGN_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear_i,
   input  logic             word_vld_i,
   input  logic [15:0]      word_data_i,
   input  logic             word_last_i,
   input  logic [RGN_W-1:0] word_region_i,
   output logic             out_valid_o,
   output logic [OUT_W-1:0] out_data_o,
   output logic [RGN_W-1:0] out_region_o,
   output logic             out_last_o
);

   localparam int LANES  = OUT_W / 16;
   localparam int LANE_W = clog2_min1(LANES);

   logic [LANE_W-1:0] lane_q, lane_d;
   logic [OUT_W-1:0]  acc_q, acc_d;
   logic              emit;

   logic              out_valid_q;
   logic [OUT_W-1:0]  out_data_q;
   logic [RGN_W-1:0]  out_region_q;
   logic              out_last_q;

   always_comb begin
      acc_d  = acc_q;
      lane_d = lane_q;
      emit   = 1'b0;
      if (word_vld_i) begin
         // Starting a fresh beat wipes every lane, which gives the zero-fill on flush.
         if (lane_q == '0) acc_d = '0;
         for (int l = 0; l < LANES; l++) begin
            if (lane_q == LANE_W'(l)) acc_d[16*l +: 16] = word_data_i;
         end
         emit   = word_last_i || (lane_q == LANE_W'(LANES - 1));
         lane_d = emit ? '0 : lane_q + LANE_W'(1);
      end
      if (clear_i) lane_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lane_q       <= '0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_region_q <= '0;
         out_last_q   <= 1'b0;
      end else begin
         lane_q      <= lane_d;
         out_valid_q <= emit;
         out_last_q  <= emit && word_last_i;
         if (emit) begin
            out_data_q   <= acc_d;
            out_region_q <= word_region_i;
         end
      end
   end

   always_ff @(posedge clk) begin
      acc_q <= acc_d;
   end

   assign out_valid_o  = out_valid_q;
   assign out_data_o   = out_data_q;
   assign out_region_o = out_region_q;
   assign out_last_o   = out_last_q;

endmodule

// File: rtl/sd_multi_region_loader.sv
// Copies up to NUM_REGIONS SD regions back-to-back into the DDR write stream,
// packing words to OUT_W and tagging each beat with its region index.
module sd_multi_region_loader
   import sd_loader_pkg::*;
#(
   parameter int NUM_REGIONS = 4,
   parameter int OUT_W       = 32,
   parameter int CNT_W       = 24,
   parameter int TIMEOUT     = 65535
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                start,
   input  logic [NUM_REGIONS-1:0]              cfg_en,
   input  logic [NUM_REGIONS*32-1:0]           cfg_sec_addr,
   input  logic [NUM_REGIONS*CNT_W-1:0]        cfg_word_cnt,
   input  logic                                rd_busy,
   input  logic                                sd_rd_val_en,
   input  logic [15:0]                         sd_rd_val_data,
   output logic                                rd_start_en,
   output logic [31:0]                         rd_sec_addr,
   output logic                                out_valid,
   output logic [OUT_W-1:0]                    out_data,
   output logic [clog2_min1(NUM_REGIONS)-1:0]  out_region,
   output logic                                out_last,
   output logic                                busy,
   output logic                                done,
   output logic                                err
);

   localparam int RGN_W = clog2_min1(NUM_REGIONS);
   localparam int IDX_W = clog2_min1(NUM_REGIONS + 1);
   localparam int TMO_W = clog2_min1(TIMEOUT + 1);

   state_t                        state_q, state_d;
   logic [IDX_W-1:0]              idx_q, idx_d;
   logic [RGN_W-1:0]              region_q, region_d;
   logic [31:0]                   sector_q, sector_d;
   logic [CNT_W-1:0]              left_q, left_d;
   logic                          rd_start_q, rd_start_d;
   logic [31:0]                   rd_addr_q, rd_addr_d;
   logic                          err_q, err_d;
   logic [TMO_W-1:0]              tmo_q, tmo_d;
   logic [SEC_CNT_W-1:0]          secw_q, secw_d;

   logic [NUM_REGIONS-1:0]        en_q;
   logic [NUM_REGIONS*32-1:0]     sec_cfg_q;
   logic [NUM_REGIONS*CNT_W-1:0]  cnt_cfg_q;

   logic                          start_acc;
   logic                          sel_found;
   logic [RGN_W-1:0]              sel_rgn;
   logic [31:0]                   sel_sec;
   logic [CNT_W-1:0]              sel_cnt;
   logic                          word_vld;
   logic                          word_last;

   // A start coinciding with done lands in ST_DONE and is therefore dropped.
   assign start_acc = (state_q == ST_IDLE) && start;

   always_ff @(posedge clk) begin
      if (start_acc) begin
         en_q      <= cfg_en;
         sec_cfg_q <= cfg_sec_addr;
         cnt_cfg_q <= cfg_word_cnt;
      end
   end

   // Lowest-numbered live region at or after idx_q; disabled or empty ones are skipped.
   always_comb begin
      sel_found = 1'b0;
      sel_rgn   = '0;
      sel_sec   = '0;
      sel_cnt   = '0;
      for (int i = 0; i < NUM_REGIONS; i++) begin
         if (!sel_found && (IDX_W'(i) >= idx_q) && en_q[i] &&
             (cnt_cfg_q[CNT_W*i +: CNT_W] != '0)) begin
            sel_found = 1'b1;
            sel_rgn   = RGN_W'(i);
            sel_sec   = sec_cfg_q[32*i +: 32];
            sel_cnt   = cnt_cfg_q[CNT_W*i +: CNT_W];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      region_d   = region_q;
      sector_d   = sector_q;
      left_d     = left_q;
      rd_start_d = 1'b0;
      rd_addr_d  = rd_addr_q;
      err_d      = err_q;
      tmo_d      = tmo_q;
      secw_d     = secw_q;
      word_vld   = 1'b0;
      word_last  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_SELECT;
               idx_d   = '0;
               err_d   = 1'b0;
            end
         end
         ST_SELECT: begin
            if (sel_found) begin
               region_d = sel_rgn;
               sector_d = sel_sec;
               left_d   = sel_cnt;
               state_d  = ST_ISSUE;
            end else begin
               state_d = ST_DONE;
            end
         end
         ST_ISSUE: begin
            rd_start_d = 1'b1;
            rd_addr_d  = sector_q;
            tmo_d      = '0;
            secw_d     = '0;
            state_d    = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (rd_busy) begin
               state_d = ST_XFER;
            end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         ST_XFER: begin
            if (sd_rd_val_en) begin
               if (secw_q != '1) secw_d = secw_q + SEC_CNT_W'(1);
               // Words past the region's count still drain from the SD but are dropped.
               if (left_q != '0) begin
                  word_vld  = 1'b1;
                  word_last = (left_q == CNT_W'(1));
                  left_d    = left_q - CNT_W'(1);
               end
            end
            if (!rd_busy) begin
               if (secw_d != SEC_CNT_W'(SECTOR_WORDS)) err_d = 1'b1;
               if (left_d == '0) begin
                  idx_d   = IDX_W'(region_q) + IDX_W'(1);
                  state_d = ST_SELECT;
               end else begin
                  sector_d = sector_q + 32'd1;
                  state_d  = ST_ISSUE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         region_q   <= '0;
         sector_q   <= '0;
         left_q     <= '0;
         rd_start_q <= 1'b0;
         rd_addr_q  <= '0;
         err_q      <= 1'b0;
         tmo_q      <= '0;
         secw_q     <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         region_q   <= region_d;
         sector_q   <= sector_d;
         left_q     <= left_d;
         rd_start_q <= rd_start_d;
         rd_addr_q  <= rd_addr_d;
         err_q      <= err_d;
         tmo_q      <= tmo_d;
         secw_q     <= secw_d;
      end
   end

   sd_word_packer #(
      .OUT_W (OUT_W),
      .RGN_W (RGN_W)
   ) u_packer (
      .clk           (clk),
      .rst_n         (rst_n),
      .clear_i       (start_acc),
      .word_vld_i    (word_vld),
      .word_data_i   (sd_rd_val_data),
      .word_last_i   (word_last),
      .word_region_i (region_q),
      .out_valid_o   (out_valid),
      .out_data_o    (out_data),
      .out_region_o  (out_region),
      .out_last_o    (out_last)
   );

   assign rd_start_en = rd_start_q;
   assign rd_sec_addr = rd_addr_q;
   assign busy        = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign done        = (state_q == ST_DONE);
   assign err         = err_q;

endmodule
